// File: rtl/sdes_pkg.sv
// S-DES shared definitions: FSM encoding, request bundle, fixed permutations
// and S-box lookups. Permutation tables count bit 1 as the MSB, so table entry p
// on an n-bit word selects bit [n-p].
package sdes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY  = 3'd1,
        IPR  = 3'd2,
        RND1 = 3'd3,
        RND2 = 3'd4,
        OUT  = 3'd5
    } sdes_state_e;

    // Request captured at accept; held stable for the whole block
    typedef struct packed {
        logic [9:0] key;
        logic [7:0] blk;
        logic       mode;
    } sdes_req_t;

    // S-box contents, indexed by {row, col} = {a3, a0, a2, a1}
    localparam logic [1:0] S0_TBL [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };
    localparam logic [1:0] S1_TBL [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    // P10 = 3 5 2 7 4 10 1 9 8 6
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    // P8 = 6 3 7 4 8 5 10 9 (10 bits in, 8 bits out)
    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    // IP = 2 6 3 1 4 8 5 7
    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    // IP^-1 = 4 1 3 5 7 2 8 6
    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    // EP = 4 1 2 3 2 3 4 1 (4 bits in, 8 bits out)
    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    // P4 = 2 4 3 1
    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [1:0] sbox0(input logic [3:0] a);
        logic [3:0] idx;
        idx = {a[3], a[0], a[2], a[1]};
        return S0_TBL[idx];
    endfunction

    function automatic logic [1:0] sbox1(input logic [3:0] a);
        logic [3:0] idx;
        idx = {a[3], a[0], a[2], a[1]};
        return S1_TBL[idx];
    endfunction

    function automatic logic [4:0] rol5(input logic [4:0] x, input int unsigned n);
        logic [4:0] y;
        y = x;
        for (int unsigned i = 0; i < n; i++) y = {y[3:0], y[4]};
        return y;
    endfunction

    // Subkey schedule: returns {K1, K2}
    function automatic logic [15:0] keygen(input logic [9:0] k);
        logic [9:0] p;
        logic [4:0] l1, r1, l2, r2;
        p  = p10(k);
        l1 = rol5(p[9:5], 1);
        r1 = rol5(p[4:0], 1);
        l2 = rol5(l1, 2);
        r2 = rol5(r1, 2);
        return {p8({l1, r1}), p8({l2, r2})};
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// One combinational S-DES round function: L' = L ^ P4(S0 | S1 of EP(R) ^ K).
// R passes through untouched; the caller decides whether halves swap.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [3:0] l,
    input  logic [3:0] r,
    input  logic [7:0] rk,
    output logic [3:0] l_out
);

    logic [7:0] mix;
    logic [3:0] sout;

    assign mix   = ep(r) ^ rk;
    assign sout  = {sbox0(mix[7:4]), sbox1(mix[3:0])};
    assign l_out = l ^ p4(sout);

endmodule

// File: rtl/sdes_engine_ctrl.sv
// Multi-cycle S-DES engine controller. One block in flight; the sequence is
// KEY -> IPR -> RND1 -> RND2 -> OUT, with KEY skipped when the request key
// matches the last fully generated key schedule.
module sdes_engine_ctrl
    import sdes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [9:0] key_in,
    input  logic [7:0] din,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout
);

    sdes_state_e state, state_nxt;
    sdes_req_t   req_r;
    logic [7:0]  k1, k2;
    logic [9:0]  cached_key;
    logic        cache_valid;
    logic [3:0]  l_r, r_r;
    logic [3:0]  fk_l;
    logic [7:0]  rk;
    logic [15:0] sched;
    logic        cache_hit;
    logic        accept;

    assign cache_hit = KEY_CACHE && cache_valid && (key_in == cached_key);
    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign sched     = keygen(req_r.key);

    // Encrypt uses K1 then K2; decrypt reverses the order
    assign rk = ((state == RND1) != req_r.mode) ? k1 : k2;

    sdes_fk u_fk (
        .l     (l_r),
        .r     (r_r),
        .rk    (rk),
        .l_out (fk_l)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: abort is ignored in IDLE so a simultaneous start wins
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = cache_hit ? IPR : KEY;
            KEY:  state_nxt = abort ? IDLE : IPR;
            IPR:  state_nxt = abort ? IDLE : RND1;
            RND1: state_nxt = abort ? IDLE : RND2;
            RND2: state_nxt = abort ? IDLE : OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, subkey registers and key cache
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r       <= '0;
            k1          <= '0;
            k2          <= '0;
            cached_key  <= '0;
            cache_valid <= 1'b0;
        end else begin
            if (accept) begin
                req_r <= '{key: key_in, blk: din, mode: mode};
                // Invalidate up front so an aborted KEY leaves no stale hit
                if (!cache_hit) cache_valid <= 1'b0;
            end
            if (state == KEY && !abort) begin
                k1          <= sched[15:8];
                k2          <= sched[7:0];
                cached_key  <= req_r.key;
                cache_valid <= 1'b1;
            end
        end
    end

    // Data halves: RND1 applies the swap, RND2 does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_r <= '0;
            r_r <= '0;
        end else if (!abort) begin
            case (state)
                IPR:     {l_r, r_r} <= ip(req_r.blk);
                RND1:    {l_r, r_r} <= {r_r, fk_l};
                RND2:    {l_r, r_r} <= {fk_l, r_r};
                default: ;
            endcase
        end
    end

    // Result register and one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == OUT && !abort) begin
                dout <= ip_inv({l_r, r_r});
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdes_engine_ctrl.sv
// Directed bench for sdes_engine_ctrl with an independent table-driven S-DES model.
module tb_sdes_engine_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] key_in = '0;
    logic [7:0] din = '0;
    logic       busy, done;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdes_engine_ctrl #(.KEY_CACHE(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .key_in (key_in),
        .din    (din),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    // ---------------- reference model ----------------
    localparam logic [63:0] T_P10   = 64'h35274A1986;
    localparam logic [63:0] T_P8    = 64'h637485A9;
    localparam logic [63:0] T_IP    = 64'h26314857;
    localparam logic [63:0] T_IPINV = 64'h41357286;
    localparam logic [63:0] T_EP    = 64'h41232341;
    localparam logic [63:0] T_P4    = 64'h2431;

    int s0m [4][4] = '{'{1,0,3,2}, '{3,2,1,0}, '{0,2,1,3}, '{3,1,3,2}};
    int s1m [4][4] = '{'{0,1,2,3}, '{2,0,1,3}, '{3,0,1,0}, '{2,1,0,3}};

    function automatic logic [15:0] perm(input logic [15:0] x, input int n_in,
                                         input int n_out, input logic [63:0] tbl);
        logic [15:0] o;
        int p;
        o = '0;
        for (int i = 0; i < n_out; i++) begin
            p = int'(tbl[4*(n_out-1-i) +: 4]);
            o[n_out-1-i] = x[n_in-p];
        end
        return o;
    endfunction

    function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] k);
        logic [15:0] e, p;
        logic [7:0]  x;
        logic [1:0]  a, b;
        e = perm({12'h0, r}, 4, 8, T_EP);
        x = e[7:0] ^ k;
        a = 2'(s0m[{x[7], x[4]}][{x[6], x[5]}]);
        b = 2'(s1m[{x[3], x[0]}][{x[2], x[1]}]);
        p = perm({12'h0, a, b}, 4, 4, T_P4);
        return p[3:0];
    endfunction

    function automatic logic [15:0] m_keys(input logic [9:0] k);
        logic [15:0] p, a, b;
        logic [4:0]  l, r;
        p = perm({6'h0, k}, 10, 10, T_P10);
        l = p[9:5]; r = p[4:0];
        l = {l[3:0], l[4]}; r = {r[3:0], r[4]};
        a = perm({6'h0, l, r}, 10, 8, T_P8);
        l = {l[2:0], l[4:3]}; r = {r[2:0], r[4:3]};
        b = perm({6'h0, l, r}, 10, 8, T_P8);
        return {a[7:0], b[7:0]};
    endfunction

    function automatic logic [7:0] m_sdes(input logic [9:0] k, input logic [7:0] x, input logic m);
        logic [15:0] ks, t;
        logic [7:0]  ka, kb;
        logic [3:0]  l, r, tmp;
        ks = m_keys(k);
        ka = m ? ks[7:0] : ks[15:8];
        kb = m ? ks[15:8] : ks[7:0];
        t = perm({8'h0, x}, 8, 8, T_IP);
        l = t[7:4]; r = t[3:0];
        l = l ^ m_f(r, ka);
        tmp = l; l = r; r = tmp;
        l = l ^ m_f(r, kb);
        t = perm({8'h0, l, r}, 8, 8, T_IPINV);
        return t[7:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for done
    task automatic run_op(input logic [9:0] k, input logic [7:0] d, input logic m,
                          input logic ab, output logic [7:0] res, output int lat);
        @(negedge clk);
        key_in = k; din = d; mode = m; start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", {31'h0, done}, 32'h1);
        res = dout;
    endtask

    localparam logic [9:0] KEY_A = 10'b1010000010;

    initial begin
        logic [7:0] res, exp_v;
        int lat, nd, cyc, idx, extra;
        logic [7:0] blk [3];
        logic [7:0] got [3];
        int tdn [3];
        logic [9:0] rk;

        // Reset state
        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_dout", {24'h0, dout}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // 1: textbook encrypt, full KEY path
        run_op(KEY_A, 8'b10010111, 1'b0, 1'b0, res, lat);
        check("t1_dout", {24'h0, res}, 32'h38);
        check("t1_lat", lat, 5);
        check("t1_k1", {24'h0, dut.k1}, 32'hA4);
        check("t1_k2", {24'h0, dut.k2}, 32'h43);
        check("t1_busy_at_done", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("t1_done_pulse", {31'h0, done}, 32'h0);
        check("t1_dout_hold", {24'h0, dout}, 32'h38);

        // 2: decrypt, cache hit, abort asserted with start (start wins)
        run_op(KEY_A, 8'b00111000, 1'b1, 1'b1, res, lat);
        check("t2_dout", {24'h0, res}, 32'h97);
        check("t2_lat", lat, 4);

        // 3: start held high, three blocks back to back
        blk[0] = 8'h00; blk[1] = 8'hFF; blk[2] = 8'h5A;
        idx = 0; nd = 0; cyc = 0;
        while (nd < 3 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (done) begin got[nd] = dout; tdn[nd] = cyc; nd++; end
            if (!busy) begin
                if (idx < 3) begin
                    key_in = 10'b0111111101; mode = 1'b0; din = blk[idx]; start = 1'b1; idx++;
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        check("t3_ndone", nd, 3);
        if (nd == 3) begin
            for (int i = 0; i < 3; i++)
                check("t3_dout", {24'h0, got[i]}, {24'h0, m_sdes(10'b0111111101, blk[i], 1'b0)});
            check("t3_gap01", tdn[1] - tdn[0], 5);
            check("t3_gap12", tdn[2] - tdn[1], 5);
        end
        extra = 0;
        repeat (8) begin @(negedge clk); if (done) extra++; end
        check("t3_no_extra", extra, 0);

        // 4: start pulsed during RND1 is ignored
        @(negedge clk); key_in = 10'h2C5; din = 8'hC3; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_busy_rnd1", {31'h0, busy}, 32'h1);
        start = 1'b1; din = 8'h11; key_in = 10'h000;
        @(negedge clk); start = 1'b0;
        nd = 0; res = 8'h00;
        repeat (12) begin @(negedge clk); if (done) begin nd++; res = dout; end end
        exp_v = m_sdes(10'h2C5, 8'hC3, 1'b0);
        check("t4_ndone", nd, 1);
        check("t4_dout", {24'h0, res}, {24'h0, exp_v});

        // 5: abort in RND2
        @(negedge clk); key_in = 10'h155; din = 8'h3C; mode = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_done", {31'h0, done}, 32'h0);
        check("t5_dout_kept", {24'h0, dout}, {24'h0, exp_v});
        nd = 0;
        repeat (6) begin @(negedge clk); if (done) nd++; end
        check("t5_no_done", nd, 0);
        run_op(10'h155, 8'h3C, 1'b1, 1'b0, res, lat);
        check("t5_restart_dout", {24'h0, res}, {24'h0, m_sdes(10'h155, 8'h3C, 1'b1)});
        check("t5_restart_lat", lat, 4);

        // abort during KEY leaves the cache invalid
        @(negedge clk); key_in = 10'h3F0; din = 8'hA5; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("tk_busy", {31'h0, busy}, 32'h0);
        check("tk_cache_valid", {31'h0, dut.cache_valid}, 32'h0);
        run_op(10'h3F0, 8'hA5, 1'b0, 1'b0, res, lat);
        check("tk_lat", lat, 5);
        check("tk_dout", {24'h0, res}, {24'h0, m_sdes(10'h3F0, 8'hA5, 1'b0)});

        // 6: reset asserted during RND1
        @(negedge clk); key_in = 10'h0F3; din = 8'h69; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_done", {31'h0, done}, 32'h0);
        check("t6_dout", {24'h0, dout}, 32'h0);
        check("t6_k1", {24'h0, dut.k1}, 32'h0);
        check("t6_cache", {31'h0, dut.cache_valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        run_op(10'h0F3, 8'h69, 1'b0, 1'b0, res, lat);
        check("t6_lat", lat, 5);
        check("t6_dout", {24'h0, res}, {24'h0, m_sdes(10'h0F3, 8'h69, 1'b0)});

        // Round trip: all blocks under 8 random keys
        for (int kk = 0; kk < 8; kk++) begin
            rk = 10'($urandom_range(0, 1023));
            for (int x = 0; x < 256; x++) begin
                run_op(rk, 8'(x), 1'b0, 1'b0, res, lat);
                check("rt_enc", {24'h0, res}, {24'h0, m_sdes(rk, 8'(x), 1'b0)});
                run_op(rk, res, 1'b1, 1'b0, exp_v, lat);
                check("rt_dec", {24'h0, exp_v}, x);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
